// File: rtl/addsub_serial_nbits.sv
// Multi-cycle adder/subtractor: walks the operands chunk bits per clock, LSB first,
// and presents a registered result and flags with a start/busy/done handshake.
module addsub_serial_nbits #(
    parameter int width = 8,
    parameter int chunk = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int N  = width / chunk;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [width-1:0] a_sh, b_sh, acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [chunk:0]   csum;
    logic [width-1:0] acc_nx;
    logic             last;

    // Operands shift right each cycle so the active chunk is always the low bits;
    // the chunk sum enters the accumulator from the top.
    always_comb begin
        csum   = (chunk+1)'(a_sh[chunk-1:0]) + (chunk+1)'(b_sh[chunk-1:0]) + (chunk+1)'(carry);
        acc_nx = (acc >> chunk) | (width'(csum[chunk-1:0]) << (width - chunk));
        last   = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_o    <= '0;
            cout_o <= 1'b0;
            ovf_o  <= 1'b0;
            zero_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        a_sh   <= a_i;
                        b_sh   <= mode_i ? ~b_i : b_i;
                        carry  <= mode_i;
                        cnt    <= '0;
                        acc    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_nx;
                    carry <= csum[chunk];
                    a_sh  <= a_sh >> chunk;
                    b_sh  <= b_sh >> chunk;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // On the last chunk the low bits of a_sh/b_sh hold the operand MSBs.
                        s_o    <= acc_nx;
                        cout_o <= csum[chunk];
                        ovf_o  <= (a_sh[chunk-1] == b_sh[chunk-1]) && (csum[chunk-1] != a_sh[chunk-1]);
                        zero_o <= (acc_nx == '0);
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
